// File: rtl/aha_sif_to_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aha_sif_to_sram_pkg
// Description : Shared widths and the byte-address to word-index mapping
//               used by the SIF-to-SRAM adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package aha_sif_to_sram_pkg;

    localparam int SIF_ADDR_W = 32;   // SIF byte address width
    localparam int SIF_DATA_W = 64;   // SIF / SRAM data width
    localparam int SIF_STRB_W = 8;    // one enable per data byte
    localparam int SIF_OFS_W  = 3;    // byte-offset bits inside a 64-bit word

    // Drops the byte offset; callers keep only the low RAM_ADDR_W bits, so
    // higher address bits alias onto the same SRAM words.
    function automatic logic [SIF_ADDR_W-1:0] sif_word_idx(input logic [SIF_ADDR_W-1:0] addr);
        return addr >> SIF_OFS_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aha_sif_if.sv
`default_nettype none
// ============================================================================
// Module      : aha_sif_if
// Description : Simple interface (SIF) write and read channels between the
//               AXI-to-SIF bridge (master) and its consumer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface aha_sif_if;
    import aha_sif_to_sram_pkg::*;

    logic [SIF_ADDR_W-1:0] SIF_WR_ADDR;
    logic                  SIF_WR_EN;
    logic [SIF_STRB_W-1:0] SIF_WR_STRB;
    logic [SIF_DATA_W-1:0] SIF_WR_DATA;
    logic [SIF_ADDR_W-1:0] SIF_RD_ADDR;
    logic                  SIF_RD_EN;
    logic [SIF_DATA_W-1:0] SIF_RD_DATA;
    logic                  SIF_RD_VALID;

    modport master (
        output SIF_WR_ADDR, SIF_WR_EN, SIF_WR_STRB, SIF_WR_DATA,
        output SIF_RD_ADDR, SIF_RD_EN,
        input  SIF_RD_DATA, SIF_RD_VALID
    );

    modport slave (
        input  SIF_WR_ADDR, SIF_WR_EN, SIF_WR_STRB, SIF_WR_DATA,
        input  SIF_RD_ADDR, SIF_RD_EN,
        output SIF_RD_DATA, SIF_RD_VALID
    );

endinterface
`default_nettype wire

// File: rtl/aha_sif_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aha_sif_rd_fifo
// Description : Small synchronous FIFO with a combinational head. A push
//               while full is accepted only when a pop happens in the same
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_sif_rd_fifo #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int WIDTH = 12
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] din_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one wrap bit to tell full from empty.
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W:0]     rd_ptr_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign head_o    = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer update; reset discards all queued entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/aha_sif_to_sram.sv
`default_nettype none
// ============================================================================
// Module      : aha_sif_to_sram
// Description : Maps the SIF write/read channels onto one single-port,
//               byte-enabled 64-bit SRAM. Writes win the port; reads queue
//               in a FIFO and return in order with SIF_RD_VALID.
// Revision    : 1.0 - initial release
// ============================================================================
module aha_sif_to_sram
    import aha_sif_to_sram_pkg::*;
#(
    parameter int RAM_ADDR_W    = 12,
    parameter int RAM_RD_LAT    = 1,   // 1..3
    parameter int RD_FIFO_DEPTH = 4
) (
    input  wire logic                  ACLK,
    input  wire logic                  ARESETn,
    aha_sif_if.slave                   sif,
    output logic                       RAM_CE,
    output logic                       RAM_WE,
    output logic [SIF_STRB_W-1:0]      RAM_BE,
    output logic [RAM_ADDR_W-1:0]      RAM_ADDR,
    output logic [SIF_DATA_W-1:0]      RAM_WDATA,
    input  wire logic [SIF_DATA_W-1:0] RAM_RDATA,
    output logic                       RD_OVERFLOW
);

    logic                  wr_pend_q;
    logic [RAM_ADDR_W-1:0] wr_addr_q;
    logic [SIF_STRB_W-1:0] wr_strb_q;
    logic [SIF_DATA_W-1:0] wr_data_q;

    logic [RAM_RD_LAT-1:0] rd_vld_q;
    logic                  rd_valid_q;
    logic [SIF_DATA_W-1:0] rd_data_q;
    logic                  rd_ovf_q;
    logic                  rd_ovf_d;

    logic [SIF_ADDR_W-1:0] w_wr_word;
    logic [SIF_ADDR_W-1:0] w_rd_word;
    logic [RAM_ADDR_W-1:0] w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_rd_issue;
    logic                  w_unused;

    assign w_wr_word = sif_word_idx(sif.SIF_WR_ADDR);
    assign w_rd_word = sif_word_idx(sif.SIF_RD_ADDR);
    assign w_unused  = ^{w_wr_word[SIF_ADDR_W-1:RAM_ADDR_W], w_rd_word[SIF_ADDR_W-1:RAM_ADDR_W]};

    // A registered write always owns the port; the read head waits behind it.
    assign w_rd_issue = !wr_pend_q && !w_fifo_empty;

    aha_sif_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .WIDTH (RAM_ADDR_W)
    ) u_rd_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .push_i  (sif.SIF_RD_EN),
        .pop_i   (w_rd_issue),
        .din_i   (w_rd_word[RAM_ADDR_W-1:0]),
        .head_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Register the incoming write so it issues one cycle later.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_pend_q <= sif.SIF_WR_EN;
            if (sif.SIF_WR_EN) begin
                wr_addr_q <= w_wr_word[RAM_ADDR_W-1:0];
                wr_strb_q <= sif.SIF_WR_STRB;
                wr_data_q <= sif.SIF_WR_DATA;
            end
        end
    end

    // Drive the SRAM port: pending write, else FIFO head read, else idle.
    always_comb begin
        RAM_CE    = 1'b0;
        RAM_WE    = 1'b0;
        RAM_BE    = '0;
        RAM_ADDR  = '0;
        RAM_WDATA = '0;
        if (wr_pend_q) begin
            RAM_CE    = 1'b1;
            RAM_WE    = 1'b1;
            RAM_BE    = wr_strb_q;
            RAM_ADDR  = wr_addr_q;
            RAM_WDATA = wr_data_q;
        end else if (!w_fifo_empty) begin
            RAM_CE    = 1'b1;
            RAM_ADDR  = w_fifo_head;
        end
    end

    // A request dropped on a full FIFO with no simultaneous pop is sticky.
    assign rd_ovf_d = rd_ovf_q || (sif.SIF_RD_EN && w_fifo_full && !w_rd_issue);

    // Track issued reads through the SRAM latency and capture returning data.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_vld_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_vld_q[0] <= w_rd_issue;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
            end
            rd_valid_q <= rd_vld_q[RAM_RD_LAT-1];
            if (rd_vld_q[RAM_RD_LAT-1]) rd_data_q <= RAM_RDATA;
            rd_ovf_q <= rd_ovf_d;
        end
    end

    assign sif.SIF_RD_VALID = rd_valid_q;
    assign sif.SIF_RD_DATA  = rd_data_q;
    assign RD_OVERFLOW      = rd_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_aha_sif_to_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_aha_sif_to_sram
// Description : Directed self-checking bench for aha_sif_to_sram with a
//               byte-enabled SRAM model of read latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aha_sif_to_sram;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b0;
    logic        RAM_CE;
    logic        RAM_WE;
    logic [7:0]  RAM_BE;
    logic [11:0] RAM_ADDR;
    logic [63:0] RAM_WDATA;
    logic [63:0] RAM_RDATA = 64'h0;
    logic        RD_OVERFLOW;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mem [0:4095];

    aha_sif_if sif();

    aha_sif_to_sram #(
        .RAM_ADDR_W    (12),
        .RAM_RD_LAT    (1),
        .RD_FIFO_DEPTH (4)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .sif         (sif),
        .RAM_CE      (RAM_CE),
        .RAM_WE      (RAM_WE),
        .RAM_BE      (RAM_BE),
        .RAM_ADDR    (RAM_ADDR),
        .RAM_WDATA   (RAM_WDATA),
        .RAM_RDATA   (RAM_RDATA),
        .RD_OVERFLOW (RD_OVERFLOW)
    );

    always #5 ACLK = ~ACLK;

    // SRAM model: byte-enabled write, read data valid one cycle after CE.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 64'h0;
    end

    always @(posedge ACLK) begin
        if (RAM_CE) begin
            if (RAM_WE) begin
                for (int b = 0; b < 8; b++) begin
                    if (RAM_BE[b]) mem[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
                end
            end else begin
                RAM_RDATA <= mem[RAM_ADDR];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected summary before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge ACLK);
    endtask

    task automatic idle();
        sif.SIF_WR_EN = 1'b0;
        sif.SIF_RD_EN = 1'b0;
    endtask

    task automatic drv_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        sif.SIF_WR_ADDR = a;
        sif.SIF_WR_DATA = d;
        sif.SIF_WR_STRB = s;
        sif.SIF_WR_EN   = 1'b1;
    endtask

    task automatic drv_rd(input logic [31:0] a);
        sif.SIF_RD_ADDR = a;
        sif.SIF_RD_EN   = 1'b1;
    endtask

    initial begin
        int nv;
        sif.SIF_WR_ADDR = '0;
        sif.SIF_WR_DATA = '0;
        sif.SIF_WR_STRB = '0;
        sif.SIF_RD_ADDR = '0;
        idle();
        repeat (3) cyc();

        // Reset state
        chk("rst_ce",    64'(RAM_CE), 64'h0);
        chk("rst_we",    64'(RAM_WE), 64'h0);
        chk("rst_be",    64'(RAM_BE), 64'h0);
        chk("rst_addr",  64'(RAM_ADDR), 64'h0);
        chk("rst_wdata", RAM_WDATA, 64'h0);
        chk("rst_valid", 64'(sif.SIF_RD_VALID), 64'h0);
        chk("rst_rdata", sif.SIF_RD_DATA, 64'h0);
        chk("rst_ovf",   64'(RD_OVERFLOW), 64'h0);
        ARESETn = 1'b1;

        // Single write then read of word 8
        drv_wr(32'h40, 64'h1122334455667788, 8'hFF);
        cyc(); idle();
        chk("t1_wr_ce",    64'(RAM_CE), 64'h1);
        chk("t1_wr_we",    64'(RAM_WE), 64'h1);
        chk("t1_wr_addr",  64'(RAM_ADDR), 64'h8);
        chk("t1_wr_be",    64'(RAM_BE), 64'hFF);
        chk("t1_wr_wdata", RAM_WDATA, 64'h1122334455667788);
        cyc();
        chk("t1_idle_ce", 64'(RAM_CE), 64'h0);
        cyc(); cyc(); cyc();
        drv_rd(32'h40);
        cyc(); idle();
        chk("t1_rd_ce",   64'(RAM_CE), 64'h1);
        chk("t1_rd_we",   64'(RAM_WE), 64'h0);
        chk("t1_rd_addr", 64'(RAM_ADDR), 64'h8);
        cyc();
        chk("t1_valid_early", 64'(sif.SIF_RD_VALID), 64'h0);
        cyc();
        chk("t1_valid", 64'(sif.SIF_RD_VALID), 64'h1);
        chk("t1_data",  sif.SIF_RD_DATA, 64'h1122334455667788);
        cyc();
        chk("t1_valid_pulse", 64'(sif.SIF_RD_VALID), 64'h0);
        chk("t1_data_hold",   sif.SIF_RD_DATA, 64'h1122334455667788);

        // Same-cycle write and read to word 2: write first, read sees new data
        drv_wr(32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        drv_rd(32'h10);
        cyc(); idle();
        chk("t2_wr_we",   64'(RAM_WE), 64'h1);
        chk("t2_wr_addr", 64'(RAM_ADDR), 64'h2);
        chk("t2_wr_be",   64'(RAM_BE), 64'h0F);
        cyc();
        chk("t2_rd_ce", 64'(RAM_CE), 64'h1);
        chk("t2_rd_we", 64'(RAM_WE), 64'h0);
        cyc();
        chk("t2_valid_early", 64'(sif.SIF_RD_VALID), 64'h0);
        cyc();
        chk("t2_valid", 64'(sif.SIF_RD_VALID), 64'h1);
        chk("t2_data",  sif.SIF_RD_DATA, 64'h00000000AAAAAAAA);
        cyc();

        // Byte strobes: all ones, then clear bytes 0 and 7
        drv_wr(32'h100, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        cyc();
        drv_wr(32'h100, 64'h0, 8'h81);
        cyc(); idle();
        drv_rd(32'h100);
        cyc(); idle();
        chk("t3_rd_we",   64'(RAM_WE), 64'h0);
        chk("t3_rd_addr", 64'(RAM_ADDR), 64'h20);
        cyc(); cyc();
        chk("t3_valid", 64'(sif.SIF_RD_VALID), 64'h1);
        chk("t3_data",  sif.SIF_RD_DATA, 64'h00FFFFFFFFFFFF00);
        cyc();

        // Throughput: preload words 0..3, then 4 back-to-back reads
        for (int i = 0; i < 4; i++) begin
            drv_wr(32'(i * 8), 64'h0123456789ABCD00 | 64'(i), 8'hFF);
            cyc();
        end
        idle();
        cyc();
        for (int c = 5; c <= 12; c++) begin
            idle();
            if (c <= 8) drv_rd(32'((c - 5) * 8));
            chk($sformatf("t4_valid_c%0d", c), 64'(sif.SIF_RD_VALID),
                (c >= 8 && c <= 11) ? 64'h1 : 64'h0);
            if (c >= 8 && c <= 11)
                chk($sformatf("t4_data_c%0d", c), sif.SIF_RD_DATA,
                    64'h0123456789ABCD00 | 64'(c - 8));
            cyc();
        end
        idle();

        // Starvation and overflow: 10 writes, 5 reads, FIFO depth 4
        nv = 0;
        for (int c = 0; c <= 20; c++) begin
            idle();
            if (c < 10) drv_wr(32'h200 + 32'(c * 8), 64'hBEEF000000000000 | 64'(c), 8'hFF);
            if (c < 5)  drv_rd(c < 4 ? 32'(c * 8) : 32'h0);
            if (c == 4) chk("t5_ovf_before", 64'(RD_OVERFLOW), 64'h0);
            if (c >= 5) chk($sformatf("t5_ovf_c%0d", c), 64'(RD_OVERFLOW), 64'h1);
            if (c == 10) chk("t5_starved_we", 64'(RAM_WE), 64'h1);
            if (c == 11) begin
                chk("t5_first_rd_we",   64'(RAM_WE), 64'h0);
                chk("t5_first_rd_addr", 64'(RAM_ADDR), 64'h0);
            end
            if (sif.SIF_RD_VALID === 1'b1) nv++;
            chk($sformatf("t5_valid_c%0d", c), 64'(sif.SIF_RD_VALID),
                (c >= 13 && c <= 16) ? 64'h1 : 64'h0);
            if (c >= 13 && c <= 16)
                chk($sformatf("t5_data_c%0d", c), sif.SIF_RD_DATA,
                    64'h0123456789ABCD00 | 64'(c - 13));
            cyc();
        end
        idle();
        chk("t5_valid_count", 64'(nv), 64'd4);

        // Reset one cycle after a read issues: no valid for it
        drv_rd(32'h18);
        cyc(); idle();
        chk("t6_rd_ce",   64'(RAM_CE), 64'h1);
        chk("t6_rd_addr", 64'(RAM_ADDR), 64'h3);
        cyc();
        ARESETn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(sif.SIF_RD_VALID), 64'h0);
        chk("t6_rst_data",  sif.SIF_RD_DATA, 64'h0);
        chk("t6_rst_ovf",   64'(RD_OVERFLOW), 64'h0);
        chk("t6_rst_ce",    64'(RAM_CE), 64'h0);
        cyc();
        chk("t6_rst_valid2", 64'(sif.SIF_RD_VALID), 64'h0);
        cyc();
        ARESETn = 1'b1;
        cyc();
        chk("t6_post_valid", 64'(sif.SIF_RD_VALID), 64'h0);
        chk("t6_post_ce",    64'(RAM_CE), 64'h0);
        drv_rd(32'h08);
        cyc(); idle();
        cyc();
        chk("t6_new_valid_early", 64'(sif.SIF_RD_VALID), 64'h0);
        cyc();
        chk("t6_new_valid", 64'(sif.SIF_RD_VALID), 64'h1);
        chk("t6_new_data",  sif.SIF_RD_DATA, 64'h0123456789ABCD01);
        cyc();
        chk("t6_new_pulse", 64'(sif.SIF_RD_VALID), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
